// File: rtl/countdown_timer.sv
// Loadable down-counter with pause/resume, abort and optional auto-reload.
// A done pulse is raised during the RUN cycle in which the count sits at zero.
module countdown_timer #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_auto_reload,
  output logic [WIDTH-1:0] o_count,
  output logic             o_busy,
  output logic             o_done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} state_t;

  state_t           r_state, w_nstate;
  logic [WIDTH-1:0] r_count, w_ncount;
  logic [WIDTH-1:0] r_reload, w_nreload;
  logic             w_zero;

  assign w_zero = (r_count == '0);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_reload <= '0;
    end else begin
      r_state  <= w_nstate;
      r_count  <= w_ncount;
      r_reload <= w_nreload;
    end
  end

  always_comb begin
    w_nstate  = r_state;
    w_ncount  = r_count;
    w_nreload = r_reload;
    case (r_state)
      S_IDLE: begin
        // stop has priority, so start+stop together leaves the timer idle
        if (i_start && !i_stop) begin
          w_nreload = i_load_val;
          w_ncount  = i_load_val;
          w_nstate  = S_RUN;
        end
      end
      S_RUN: begin
        if (!w_zero) begin
          if (i_stop) w_nstate = S_PAUSE;
          else        w_ncount = r_count - WIDTH'(1);
        end else if (i_stop) begin
          w_nstate = S_IDLE;
        end else if (i_auto_reload) begin
          w_ncount = r_reload;
        end else begin
          w_nstate = S_IDLE;
        end
      end
      S_PAUSE: begin
        if (i_stop) begin
          w_nstate = S_IDLE;
          w_ncount = '0;
        end else if (i_start) begin
          w_nstate = S_RUN;
        end
      end
      default: begin
        w_nstate = S_IDLE;
        w_ncount = '0;
      end
    endcase
  end

  // outputs decode registered state only; no input reaches them combinationally
  assign o_count = r_count;
  assign o_busy  = (r_state != S_IDLE);
  assign o_done  = (r_state == S_RUN) && w_zero;

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
Loadable down-counter and timer. It is the count-down counterpart of the team's free-running up counter.
- Captures a start value, decrements once per clock, and signals terminal count with a one-cycle done pulse.
- Supports pause/resume, abort, and optional auto-reload for periodic ticks.
- Sits beside the up counter as the timing source for timeouts and periodic events.

Parameters:
WIDTH, 4, width of count, load value and reload register

Ports:
clk  input  1  system clock; all state updates on rising edge
rstn  input  1  asynchronous active-low reset
load_val  input  WIDTH  start value; sampled only when a start is accepted from IDLE
start  input  1  start from IDLE (with load), or resume from PAUSE
stop  input  1  pause from RUN; abort from PAUSE
auto_reload  input  1  sampled in RUN at count==0: 1 = reload and continue, 0 = return to IDLE
count  output  WIDTH  current count value (registered)
busy  output  1  high whenever state != IDLE (registered/decoded from state)
done  output  1  one-cycle pulse: high while count==0 in RUN

Behaviour:
- Reset (rstn low, asynchronous, any time including mid-count): state=IDLE, count=0, reload_reg=0, busy=0, done=0. After rstn rises, the first active edge is normal operation.
- States: IDLE, RUN, PAUSE. Priority when start and stop are both high: stop wins.
- IDLE:
  - start=1, stop=0, load_val=N>0: reload_reg<=N, count<=N, go to RUN.
  - start=1, load_val=0: count<=0, go to RUN. done is high the next cycle; the zero-length timer expires immediately.
  - Otherwise count holds its value.
- RUN, count>0:
  - stop=1: go to PAUSE, count holds.
  - Else count<=count-1.
  - start is ignored in RUN; no restart and no reload.
- RUN, count==0 (done=1 this cycle):
  - stop=1: go to IDLE; this is abort priority.
  - Else auto_reload=1: count<=reload_reg, stay in RUN.
  - Else: go to IDLE, count stays 0.
- PAUSE:
  - stop=1: abort to IDLE, count<=0.
  - Else start=1: go to RUN, count unchanged. Decrement resumes on the following edge.
  - Else hold.
- done = (state==RUN) && (count==0), with no combinational path from inputs.
  - One pulse per expiry.
  - Never asserted in IDLE or PAUSE.
- Timing:
  - Latency from the start edge to done = N+1 cycles: count shows N..1, then 0 with done.
  - Auto-reload period = N+1 cycles.
- Arithmetic: unsigned WIDTH-bit. The decrement is never applied at 0, so there is no wrap to all-ones.
  - Max value 2^WIDTH-1 (15 for WIDTH=4) is a legal load.
- load_val changes after start are ignored until the next start from IDLE. reload_reg is updated only by a start accepted from IDLE.

Test Plan:
- Reset: rstn low at t=0 and asynchronously mid-RUN at count=7 -> count=0, busy=0, done=0 immediately, without waiting for a clock edge.
- One-shot: load_val=5, start pulse -> count 5,4,3,2,1,0; done high only in the count=0 cycle (6th cycle after start); then IDLE, busy=0, count holds 0.
- Auto-reload: load_val=3, auto_reload=1 -> count sequence 3,2,1,0,3,2,1,0; done pulses every 4 cycles. Drop auto_reload -> returns to IDLE after the next 0.
- Pause/resume/abort:
  - load_val=9, stop at count=6 -> count holds 6 for 4 cycles with busy=1.
  - start -> resumes 5,4,...
  - stop twice in succession -> IDLE, count=0, no done.
- Boundaries:
  - load_val=0 start -> done high exactly one cycle, then IDLE.
  - load_val=15 (WIDTH=4) -> 16 cycles to done, no wrap.
  - start and stop both high in IDLE -> stays IDLE.
  - start held high through RUN -> no restart.
